// File: rtl/wide_add_seq.sv
// Byte-serial W-bit adder: one 8-bit adder ripples through NBYTES bytes, one per clock.
// Optional macro WIDE_ADD_SEQ_OVF_EN adds a registered two's-complement overflow output (ovf).
module wide_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                busy
`ifdef WIDE_ADD_SEQ_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [7:0] a_byte, b_byte;
  logic [8:0] add_res;

  // Byte select for the shared adder.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  assign add_res = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};

`ifdef WIDE_ADD_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  logic byte_ovf;

  // Same-sign operands producing a different-sign result, evaluated on the top byte.
  assign byte_ovf = (a_byte[7] == b_byte[7]) && (add_res[7] != a_byte[7]);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[i*8 +: 8] = add_res[7:0];
          end
        end
        carry_d = add_res[8];
        if (idx_q == LastIdx) begin
          cout_d  = add_res[8];
`ifdef WIDE_ADD_SEQ_OVF_EN
          ovf_d   = byte_ovf;
`endif
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 1..16); W = 8*NBYTES.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, signalling that operands are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, signalling that operands can be accepted.
REQ-006 The block SHALL have ports a and b, inputs, W bits each, the unsigned addends.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry into bit 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit, signalling that the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, signalling that the consumer accepts the result.
REQ-010 The block SHALL have port sum, output, W bits, the result a+b+cin mod 2^W.
REQ-011 The block SHALL have port cout, output, 1 bit, the carry out of bit W-1.
REQ-012 The block SHALL have port busy, output, 1 bit, high in states RUN and DONE.

Function
REQ-013 The block SHALL contain exactly one 8-bit adder datapath (8-bit a, 8-bit b, carry in -> 8-bit sum, carry out), time-shared across bytes; a W-bit combinational adder is not permitted.
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-016 Accept: in IDLE with in_valid=1, at the clock edge the block SHALL latch a, b and cin, clear the byte index to 0, and enter RUN.
REQ-017 RUN: at each edge the block SHALL add byte[idx] of the latched a and b plus the carry register, write the result into sum byte idx, update the carry register, and increment idx.
REQ-018 When idx = NBYTES-1 the block SHALL perform the final byte, write the final carry to cout, and enter DONE; out_valid SHALL therefore rise exactly NBYTES edges after the accept edge.
REQ-019 DONE: sum and cout SHALL be held stable; on an edge with out_ready=1 the block SHALL return to IDLE.
REQ-020 There SHALL be no DONE->RUN bypass: with in_valid and out_ready held high, accepts SHALL occur every NBYTES+2 cycles.
REQ-021 The block SHALL ignore in_valid outside IDLE; latched operands SHALL be unaffected by input changes after accept.
REQ-022 With NBYTES=1 the block SHALL spend exactly one cycle in RUN.
REQ-023 sum SHALL retain the last completed result in IDLE until the next operation overwrites bytes; sum is only meaningful while out_valid=1.
REQ-024 The byte index register SHALL be at least 1 bit wide and SHALL never exceed NBYTES-1.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, and SHALL clear sum, cout, the carry register, the byte index and the latched operands to 0.
REQ-026 Out of reset the block SHALL present in_ready=1, out_valid=0 and busy=0, including when reset is asserted mid-RUN or in DONE; no partial result SHALL be delivered.
REQ-027 The first edge after reset deassertion SHALL be able to accept an operation.

Configuration
REQ-028 With macro WIDE_ADD_SEQ_OVF_EN defined, the block SHALL add output port ovf (1 bit): the registered two's-complement overflow of the W-bit add (carry into bit W-1 XOR carry out of bit W-1), valid with out_valid and reset to 0. Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario (NBYTES=4): a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, and out_valid rises 4 edges after the accept edge.
REQ-030 Scenario (NBYTES=4): a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1; the carry ripples through all 4 bytes.
REQ-031 Scenario: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid stays 1, sum and cout are stable, in_ready=0, and no new accept occurs.
REQ-032 Scenario: assert reset after 2 RUN cycles -> sum=0, out_valid=0, in_ready=1 during reset; the next operation a=0x12345678, b=0x11111111 gives sum=0x23456789.
REQ-033 Scenario: in_valid=1 and out_ready=1 held for 20 cycles, NBYTES=4 -> accepts occur every 6 cycles and each result is correct.
REQ-034 Scenario (macro defined): a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, ovf=1, cout=0; without the macro the build has no ovf port.
